// File: rtl/supersonic_pkg.sv
// supersonic_pkg: shared definitions for the ultrasonic ranger and its controller.
//   - State encodings of the ranger FSM (also visible on the ranger debug port).
//   - Distance field width, the timeout code and the saturation ceiling.
//   - Width of the shared cycle counter.
package supersonic_pkg;

  localparam int CNT_W  = 22;
  localparam int DIST_W = 17;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_ECHO = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_HOLD      = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    TRIG      = ST_TRIG,
    WAIT_ECHO = ST_WAIT_ECHO,
    MEASURE   = ST_MEASURE,
    HOLD      = ST_HOLD
  } state_e;

  // Distance code reported when the measurement hits the timeout limit.
  localparam logic [DIST_W-1:0] DIST_TIMEOUT = 17'h1FFFF;
  // Largest real measurement; one below the timeout code so they never alias.
  localparam logic [DIST_W-1:0] DIST_SAT     = 17'h1FFFE;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input bit.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops
//   d     - asynchronous input
//   q     - synchronized output, two clk cycles of latency
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/supersonic_ranger.sv
// supersonic_ranger: drives an ultrasonic sensor and converts echo width to mm.
//   clk, rst_n  - clock and asynchronous active-low reset
//   trigger     - measurement request, rising edge starts a measurement from IDLE
//   trig_out    - trigger line to the sensor, high for TRIG_CYC cycles
//   triggerSuc  - one-cycle pulse in the cycle trig_out falls
//   echo        - asynchronous echo line from the sensor
//   valid       - one-cycle pulse, distance updated
//   distance    - last result in mm (17'h1FFFF on timeout), held between pulses
//   timeout     - one-cycle pulse coincident with valid when the measurement timed out
//   busy        - high whenever the FSM is not in IDLE
//   dbg_state   - current FSM state encoding
//
// Handshake: valid is a single-cycle strobe with no ready/back-pressure; the
// consumer must capture distance/timeout in the cycle valid is high (distance
// stays stable afterwards until the next valid).
module supersonic_ranger
  import supersonic_pkg::*;
#(
  parameter int TRIG_CYC = 500,
  parameter int DIV      = 291,
  parameter int TIMEOUT  = 1_900_000,
  parameter int HOLDOFF  = 3_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  output logic              triggerSuc,
  output logic              valid,
  output logic [DIST_W-1:0] distance,
  output logic              timeout,
  output logic              busy,
  output logic              trig_out,
  input  logic              echo,
  output logic [2:0]        dbg_state
);

  localparam int SUB_W = $clog2(DIV) + 1;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(DIV - 1);

  logic echo_s;

  sync2 u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .q     (echo_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [DIST_W-1:0]  acc_q, acc_d;
  logic [DIST_W-1:0]  dist_q, dist_d;
  logic               trig_prev_q;
  logic               trig_out_q, trig_out_d;
  logic               suc_q, suc_d;
  logic               valid_q, valid_d;
  logic               tmo_q, tmo_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    sub_d      = sub_q;
    acc_d      = acc_q;
    dist_d     = dist_q;
    trig_out_d = trig_out_q;
    suc_d      = 1'b0;
    valid_d    = 1'b0;
    tmo_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (trigger && !trig_prev_q) begin
          state_d    = TRIG;
          trig_out_d = 1'b1;
        end
      end

      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d    = WAIT_ECHO;
          cnt_d      = '0;
          trig_out_d = 1'b0;
          suc_d      = 1'b1;
        end
      end

      WAIT_ECHO: begin
        if (echo_s) begin
          // The cycle that detects echo is itself an echo-high cycle, so it
          // is counted here; otherwise every result would lose one cycle.
          state_d = MEASURE;
          cnt_d   = '0;
          acc_d   = '0;
          if (SUB_LAST == '0) begin
            sub_d = '0;
            acc_d = DIST_W'(1);
          end else begin
            sub_d = SUB_W'(1);
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          dist_d  = DIST_TIMEOUT;
          valid_d = 1'b1;
          tmo_d   = 1'b1;
        end
      end

      MEASURE: begin
        if (!echo_s) begin
          state_d = HOLD;
          cnt_d   = '0;
          dist_d  = acc_q;
          valid_d = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          dist_d  = DIST_TIMEOUT;
          valid_d = 1'b1;
          tmo_d   = 1'b1;
        end else if (sub_q == SUB_LAST) begin
          sub_d = '0;
          if (acc_q != DIST_SAT) acc_d = acc_q + DIST_W'(1);
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end

      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        trig_out_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sub_q       <= '0;
      acc_q       <= '0;
      dist_q      <= '0;
      trig_prev_q <= 1'b0;
      trig_out_q  <= 1'b0;
      suc_q       <= 1'b0;
      valid_q     <= 1'b0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      acc_q       <= acc_d;
      dist_q      <= dist_d;
      // Tracks trigger in every state so a level held through a busy
      // period cannot look like a fresh edge on return to IDLE.
      trig_prev_q <= trigger;
      trig_out_q  <= trig_out_d;
      suc_q       <= suc_d;
      valid_q     <= valid_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
    end
  end

  assign trig_out   = trig_out_q;
  assign triggerSuc = suc_q;
  assign valid      = valid_q;
  assign timeout    = tmo_q;
  assign distance   = dist_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/supersonic_ranger.md
SUPERSONIC_RANGER -- requirements
Module: supersonic_ranger

Interface
REQ-001 Parameter TRIG_CYC, default 500, width of the sensor trigger pulse in clk cycles (10 us at 50 MHz).
REQ-002 Parameter DIV, default 291, clk cycles of echo-high per 1 mm of distance.
REQ-003 Parameter TIMEOUT, default 1_900_000, maximum clk cycles spent in WAIT_ECHO or in MEASURE.
REQ-004 Parameter HOLDOFF, default 3_000_000, clk cycles of idle gap enforced after every measurement.
REQ-005 clk  input  1  system clock, 50 MHz, all logic on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 trigger  input  1  measurement request from the controller; rising edge is significant.
REQ-008 triggerSuc  output  1  one-cycle pulse: trigger pulse delivered to the sensor.
REQ-009 valid  output  1  one-cycle pulse: distance is updated.
REQ-010 distance  output  17  last measured distance in mm; held between valid pulses.
REQ-011 timeout  output  1  one-cycle pulse, coincident with valid, when the measurement timed out.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 trig_out  output  1  trigger line to the ultrasonic sensor.
REQ-014 echo  input  1  asynchronous echo line from the sensor.

Function
REQ-015 echo SHALL pass through a 2-flop synchronizer; all echo decisions use the synchronized value (echo_s).
REQ-016 FSM states SHALL be IDLE, TRIG, WAIT_ECHO, MEASURE, HOLD.
REQ-017 IDLE: on a rising edge of trigger (registered previous value 0, current 1), go to TRIG; a held-high trigger SHALL not retrigger.
REQ-018 TRIG: trig_out high for exactly TRIG_CYC cycles; in the cycle trig_out falls, triggerSuc pulses and the state becomes WAIT_ECHO.
REQ-019 WAIT_ECHO: echo_s high goes to MEASURE with the sub-counter and the distance accumulator cleared; TIMEOUT cycles without echo_s high go to the timeout exit.
REQ-020 MEASURE: the sub-counter counts 0..DIV-1 while echo_s is high; at wrap it increments the accumulator; the accumulator saturates at 17'h1FFFE.
REQ-021 MEASURE exit on echo_s low: the next cycle SHALL register distance = accumulator (floor of high cycles / DIV), pulse valid, and go to HOLD.
REQ-022 MEASURE lasting TIMEOUT cycles SHALL take the timeout exit.
REQ-023 Timeout exit: distance = 17'h1FFFF, valid and timeout pulse in the same cycle, and the state becomes HOLD.
REQ-024 HOLD: wait HOLDOFF cycles, then go to IDLE; trigger edges arriving in any non-IDLE state SHALL be ignored, not queued.
REQ-025 The previous-trigger register SHALL update in every state, so a trigger held high through HOLD does not fire on return to IDLE.
REQ-026 A single shared 22-bit cycle counter SHALL serve TRIG, WAIT_ECHO, MEASURE and HOLD; it is cleared on every state change.
REQ-027 An echo already high when WAIT_ECHO is entered SHALL start MEASURE immediately (no edge requirement).

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, trig_out 0, triggerSuc 0, valid 0, timeout 0, busy 0, distance 0, all counters and synchronizer flops 0.
REQ-029 Reset asserted mid-measurement SHALL abort it with no valid pulse; after release the block waits for a new trigger edge.

Structure
REQ-030 State encodings and the 17'h1FFFF timeout code SHALL be localparams in a shared package (supersonic_pkg) also used by the controller.
REQ-031 The echo synchronizer SHALL be a sub-module, sync2 (1-bit, clk, rst_n).
REQ-032 The only arithmetic is counter increments and compares; no divider or multiplier.

Verification
REQ-033 Bench overrides: TRIG_CYC=500, DIV=291, TIMEOUT=400000, HOLDOFF=100, 20 ns clock.
REQ-034 Scenario 1 (normal measurement): trigger edge -> trig_out high 500 cycles, then triggerSuc one-cycle pulse; echo high 900*291 cycles -> valid pulse, distance=900, timeout=0.
REQ-035 Scenario 2 (floor rounding): echo high 600*291+290 cycles -> distance=600.
REQ-036 Scenario 3 (no echo): no echo after the trigger -> after 400000 cycles in WAIT_ECHO, valid and timeout pulse together, distance=17'h1FFFF.
REQ-037 Scenario 4 (trigger while busy): a second trigger edge during MEASURE or HOLD -> no second trig_out; a trigger held high across HOLD yields no new measurement until it goes low and rises again.
REQ-038 Scenario 5 (reset mid-measurement): rst_n low during MEASURE -> all outputs 0 immediately, no valid pulse; the next trigger produces a normal 500-cycle trig_out.
